// File: rtl/vga_csr_responder.sv
// -----------------------------------------------------------------------------
// vga_csr_responder
//
// Memory-side responder for the VGA sequencer's CSR read port. It serves
// fixed-latency (3 cycle), pipelined word reads from a single-port synchronous
// video RAM. CPU Wishbone accesses share the same RAM port and only use
// cycles in which the sequencer is not strobing.
//
// Optional feature macro: VGA_CSR_RESP_STATS_EN
//   When defined, adds stall_cnt_o, a saturating count of cycles in which a
//   CPU request waited in IDLE because the sequencer held the RAM port.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   csr_adr_i        sequencer word address
//   csr_stb_i        sequencer read strobe (one read per high cycle)
//   csr_dat_o        sequencer read data, valid 3 cycles after the strobe
//   wb_*             CPU Wishbone slave (classic, single access)
//   mem_adr_o        RAM word address       (registered)
//   mem_dat_o        RAM write data         (registered)
//   mem_sel_o        RAM byte enables       (registered)
//   mem_rd_o         RAM read command       (registered)
//   mem_we_o         RAM write command      (registered)
//   mem_dat_i        RAM read data, valid the cycle after mem_rd_o
//   stall_cnt_o      CPU stall cycle count  (VGA_CSR_RESP_STATS_EN only)
// -----------------------------------------------------------------------------
module vga_csr_responder #(
    parameter int AW = 17,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   csr_adr_i,
    input  logic            csr_stb_i,
    output logic [DW-1:0]   csr_dat_o,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic [DW-1:0]   wb_dat_o,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic            wb_stb_i,
    input  logic            wb_cyc_i,
    output logic            wb_ack_o,
    output logic [AW-1:0]   mem_adr_o,
    output logic [DW-1:0]   mem_dat_o,
    output logic [DW/8-1:0] mem_sel_o,
    output logic            mem_rd_o,
    output logic            mem_we_o,
    input  logic [DW-1:0]   mem_dat_i
`ifdef VGA_CSR_RESP_STATS_EN
    ,
    output logic [15:0]     stall_cnt_o
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_CAPT  = 3'd2,
        ST_WR_ISSUE = 3'd3,
        ST_ACK      = 3'd4
    } cpu_state_t;

    cpu_state_t state_r;
    cpu_state_t state_nxt_s;

    logic       cpu_req_s;
    logic       cpu_rd_s;     // CPU read takes the next RAM slot
    logic       cpu_wr_s;     // CPU write takes the next RAM slot
    logic       ack_set_s;
    logic       wbdat_ld_s;

    // Read-tag pipe: stage 0 aligns with mem_rd_o, stage 1 with mem_dat_i.
    logic [1:0] rd_vld_r;
    logic [1:0] rd_csr_r;

    assign cpu_req_s = wb_cyc_i & wb_stb_i;

    // CPU FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // CPU FSM next state and slot claims. A CPU command is only decided in
    // IDLE and only when the sequencer is not strobing, so it can never
    // collide with a display read in the slot it claims.
    always_comb begin
        state_nxt_s = state_r;
        cpu_rd_s    = 1'b0;
        cpu_wr_s    = 1'b0;
        ack_set_s   = 1'b0;
        wbdat_ld_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cpu_req_s && !csr_stb_i) begin
                    if (wb_we_i) begin
                        cpu_wr_s    = 1'b1;
                        state_nxt_s = ST_WR_ISSUE;
                    end else begin
                        cpu_rd_s    = 1'b1;
                        state_nxt_s = ST_RD_ISSUE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_ISSUE: begin
                if (!wb_cyc_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RD_CAPT;
                end
            end
            ST_RD_CAPT: begin
                if (!wb_cyc_i) begin
                    // Aborted: the returning data is simply not captured.
                    state_nxt_s = ST_IDLE;
                end else begin
                    wbdat_ld_s  = rd_vld_r[1] & ~rd_csr_r[1];
                    ack_set_s   = 1'b1;
                    state_nxt_s = ST_ACK;
                end
            end
            ST_WR_ISSUE: begin
                // The write is already on the RAM port; abort only drops the ack.
                if (!wb_cyc_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    ack_set_s   = 1'b1;
                    state_nxt_s = ST_ACK;
                end
            end
            ST_ACK: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // RAM command register: display reads first, then the CPU claim.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd_o  <= 1'b0;
            mem_we_o  <= 1'b0;
            mem_adr_o <= {AW{1'b0}};
            mem_dat_o <= {DW{1'b0}};
            mem_sel_o <= {(DW/8){1'b0}};
        end else if (csr_stb_i) begin
            mem_rd_o  <= 1'b1;
            mem_we_o  <= 1'b0;
            mem_adr_o <= csr_adr_i;
        end else if (cpu_rd_s) begin
            mem_rd_o  <= 1'b1;
            mem_we_o  <= 1'b0;
            mem_adr_o <= wb_adr_i;
        end else if (cpu_wr_s) begin
            mem_rd_o  <= 1'b0;
            mem_we_o  <= 1'b1;
            mem_adr_o <= wb_adr_i;
            mem_dat_o <= wb_dat_i;
            mem_sel_o <= wb_sel_i;
        end else begin
            mem_rd_o  <= 1'b0;
            mem_we_o  <= 1'b0;
        end
    end

    // Read-tag shift register recording who issued each RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_r <= 2'b00;
            rd_csr_r <= 2'b00;
        end else begin
            rd_vld_r <= {rd_vld_r[0], csr_stb_i | cpu_rd_s};
            rd_csr_r <= {rd_csr_r[0], csr_stb_i};
        end
    end

    // Return-data steering: CSR data held until the next CSR read lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            csr_dat_o <= {DW{1'b0}};
        end else if (rd_vld_r[1] && rd_csr_r[1]) begin
            csr_dat_o <= mem_dat_i;
        end else begin
            csr_dat_o <= csr_dat_o;
        end
    end

    // CPU read data and single-cycle acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_dat_o <= {DW{1'b0}};
            wb_ack_o <= 1'b0;
        end else begin
            wb_ack_o <= ack_set_s;
            if (wbdat_ld_s) begin
                wb_dat_o <= mem_dat_i;
            end else begin
                wb_dat_o <= wb_dat_o;
            end
        end
    end

`ifdef VGA_CSR_RESP_STATS_EN
    logic        stall_s;
    logic [15:0] stall_cnt_r;

    assign stall_s     = (state_r == ST_IDLE) & cpu_req_s & csr_stb_i;
    assign stall_cnt_o = stall_cnt_r;

    // Saturating count of cycles a CPU request waited behind the sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
        end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_vga_csr_responder.sv
// -----------------------------------------------------------------------------
// tb_vga_csr_responder
//
// Self-checking bench for vga_csr_responder. A behavioural byte-lane RAM
// sits on the mem_* port. Expected CSR data is queued when a tracked strobe
// is driven and compared three cycles later. CPU transfers and CSR reads come
// from a vector table; contention, abort and reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_vga_csr_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] csr_adr_i;
    logic        csr_stb_i;
    logic [15:0] csr_dat_o;
    logic [16:0] wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;
    logic [16:0] mem_adr_o;
    logic [15:0] mem_dat_o;
    logic [1:0]  mem_sel_o;
    logic        mem_rd_o;
    logic        mem_we_o;
    logic [15:0] mem_dat_i;
`ifdef VGA_CSR_RESP_STATS_EN
    logic [15:0] stall_cnt_o;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;

    vga_csr_responder dut (
        .clk        (clk),
        .rst        (rst),
        .csr_adr_i  (csr_adr_i),
        .csr_stb_i  (csr_stb_i),
        .csr_dat_o  (csr_dat_o),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_i   (wb_sel_i),
        .wb_we_i    (wb_we_i),
        .wb_stb_i   (wb_stb_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_ack_o   (wb_ack_o),
        .mem_adr_o  (mem_adr_o),
        .mem_dat_o  (mem_dat_o),
        .mem_sel_o  (mem_sel_o),
        .mem_rd_o   (mem_rd_o),
        .mem_we_o   (mem_we_o),
        .mem_dat_i  (mem_dat_i)
`ifdef VGA_CSR_RESP_STATS_EN
        ,
        .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural RAM: byte-lane writes, one-cycle registered reads.
    logic [15:0] ram [0:511];
    logic        fill_req;

    always @(posedge clk) begin
        if (fill_req) begin
            for (int k = 0; k < 512; k++) begin
                ram[k] <= (k == 5) ? 16'hFFFF : (16'(k) ^ 16'hA5A5);
            end
        end else if (mem_we_o) begin
            if (mem_sel_o[0]) ram[mem_adr_o[8:0]][7:0]  <= mem_dat_o[7:0];
            if (mem_sel_o[1]) ram[mem_adr_o[8:0]][15:8] <= mem_dat_o[15:8];
        end
        if (mem_rd_o) mem_dat_i <= ram[mem_adr_o[8:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // CSR scoreboard: tracked strobes queue their expected data.
    logic [15:0] exp_q [$];
    logic [15:0] sb_exp;
    logic [2:0]  sdelay;
    logic        track_en;

    always @(posedge clk) begin
        if (rst) sdelay <= 3'b000;
        else     sdelay <= {sdelay[1:0], csr_stb_i & track_en};
    end

    always @(posedge clk) begin
        #1;
        if (sdelay[2]) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL csr_sb: data 0x%0h arrived with nothing expected", csr_dat_o);
            end else begin
                sb_exp = exp_q.pop_front();
                check("csr_sb", 32'(csr_dat_o), 32'(sb_exp));
            end
        end
        check("rd_we_excl", 32'(mem_rd_o & mem_we_o), 32'd0);
    end

    task automatic csr_read(input logic [16:0] adr, input logic [15:0] exp);
        csr_stb_i = 1'b1;
        csr_adr_i = adr;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        csr_stb_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    // Single Wishbone transfer; lat counts cycles from request to ack (-1 on timeout).
    task automatic cpu_xfer(input logic we, input logic [16:0] adr, input logic [15:0] dat,
                            input logic [1:0] sel, output int lat, output logic [15:0] rdata);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (wb_ack_o) begin
                lat = n;
                break;
            end
        end
        rdata    = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        @(posedge clk); #1;
        check("ack_one_cycle", 32'(wb_ack_o), 32'd0);
    endtask

    localparam logic [1:0] K_CSR = 2'd0;
    localparam logic [1:0] K_WR  = 2'd1;
    localparam logic [1:0] K_RD  = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [16:0] adr;
        logic [15:0] dat;
        logic [1:0]  sel;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs [10];
    int          lat;
    logic [15:0] rdata;
    logic        cpu_rd_seen;
    logic        ack_seen;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{K_WR,  17'h00020, 16'h1234, 2'b11, 16'h0000, 2};
        vecs[1] = '{K_RD,  17'h00020, 16'h0000, 2'b00, 16'h1234, 3};
        vecs[2] = '{K_WR,  17'h00005, 16'h00AB, 2'b01, 16'h0000, 2};
        vecs[3] = '{K_CSR, 17'h00005, 16'h0000, 2'b00, 16'hFFAB, 0};
        vecs[4] = '{K_RD,  17'h00100, 16'h0000, 2'b00, 16'hA4A5, 3};
        vecs[5] = '{K_WR,  17'h00101, 16'hBEEF, 2'b10, 16'h0000, 2};
        vecs[6] = '{K_CSR, 17'h00101, 16'h0000, 2'b00, 16'hBEA4, 0};
        vecs[7] = '{K_RD,  17'h00101, 16'h0000, 2'b00, 16'hBEA4, 3};
        vecs[8] = '{K_WR,  17'h00102, 16'h5A5A, 2'b00, 16'h0000, 2};
        vecs[9] = '{K_CSR, 17'h00102, 16'h0000, 2'b00, 16'hA4A7, 0};

        rst = 1'b1; fill_req = 1'b1; track_en = 1'b0;
        csr_stb_i = 1'b0; csr_adr_i = 17'h0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = 17'h0; wb_dat_i = 16'h0; wb_sel_i = 2'b00;
        repeat (3) begin @(posedge clk); #1; end

        // Reset state
        check("rst_csr_dat", 32'(csr_dat_o), 32'd0);
        check("rst_wb_dat",  32'(wb_dat_o),  32'd0);
        check("rst_cmds",    32'({wb_ack_o, mem_rd_o, mem_we_o}), 32'd0);
        check("rst_mem_bus", 32'({mem_adr_o, mem_sel_o}), 32'd0);
        check("rst_mem_dat", 32'(mem_dat_o), 32'd0);
        rst = 1'b0; fill_req = 1'b0;
        @(posedge clk); #1;

        // CSR streaming: eight back-to-back strobes
        track_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            csr_stb_i = 1'b1;
            csr_adr_i = 17'(32'h100 + i);
            exp_q.push_back(16'(32'h100 + i) ^ 16'hA5A5);
            @(posedge clk); #1;
        end
        csr_stb_i = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("csr_hold", 32'(csr_dat_o), 32'(16'h0107 ^ 16'hA5A5));

        // Vector table
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].kind == K_CSR) begin
                csr_read(vecs[v].adr, vecs[v].exp);
            end else begin
                cpu_xfer(vecs[v].kind == K_WR, vecs[v].adr, vecs[v].dat, vecs[v].sel, lat, rdata);
                check($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].lat));
                if (vecs[v].kind == K_RD)
                    check($sformatf("vec%0d_rdata", v), 32'(rdata), 32'(vecs[v].exp));
            end
        end

        // Contention: CPU read of 0x20 while the sequencer strobes 10 cycles
        cpu_rd_seen = 1'b0; ack_seen = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 17'h00020;
        csr_stb_i = 1'b1; csr_adr_i = 17'h00180;
        exp_q.push_back(16'h0180 ^ 16'hA5A5);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (mem_rd_o && (mem_adr_o == 17'h00020)) cpu_rd_seen = 1'b1;
            if (wb_ack_o) ack_seen = 1'b1;
            if (i < 10) begin
                csr_adr_i = 17'(32'h180 + i);
                exp_q.push_back(16'(32'h180 + i) ^ 16'hA5A5);
            end else begin
                csr_stb_i = 1'b0;
            end
        end
        check("cont_no_cpu_rd", 32'(cpu_rd_seen), 32'd0);
        check("cont_no_early_ack", 32'(ack_seen), 32'd0);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (wb_ack_o) begin
                lat = n;
                break;
            end
        end
        check("cont_ack_lat", 32'(lat), 32'd3);
        check("cont_rdata", 32'(wb_dat_o), 32'h1234);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
`ifdef VGA_CSR_RESP_STATS_EN
        check("stall_cnt", 32'(stall_cnt_o), 32'd10);
`endif

        // Abort: drop cyc during RD_CAPT of a read to 0x103
        ack_seen = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 17'h00103;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(posedge clk); #1;
        check("abort_no_ack", 32'(wb_ack_o), 32'd0);
        check("abort_discard", 32'(wb_dat_o), 32'h1234);
        cpu_xfer(1'b0, 17'h00104, 16'h0000, 2'b00, lat, rdata);
        check("abort_idle_lat", 32'(lat), 32'd3);
        check("abort_next_rd", 32'(rdata), 32'(16'h0104 ^ 16'hA5A5));
        csr_read(17'h00103, 16'h0103 ^ 16'hA5A5);

        // Reset with an untracked CSR read in flight
        csr_read(17'h00105, 16'h0105 ^ 16'hA5A5);
        track_en = 1'b0;
        csr_stb_i = 1'b1; csr_adr_i = 17'h00106;
        @(posedge clk); #1;
        csr_stb_i = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_csr_dat", 32'(csr_dat_o), 32'd0);
        check("mrst_wb", 32'({wb_ack_o, wb_dat_o}), 32'd0);
        check("mrst_cmds", 32'({mem_rd_o, mem_we_o, mem_sel_o}), 32'd0);
        check("mrst_mem_bus", 32'({mem_adr_o, mem_dat_o}), 32'd0);
`ifdef VGA_CSR_RESP_STATS_EN
        check("mrst_stall_cnt", 32'(stall_cnt_o), 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("mrst_no_stale", 32'(csr_dat_o), 32'd0);
        end
        track_en = 1'b1;
        csr_read(17'h00106, 16'h0106 ^ 16'hA5A5);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
